pbkdf2_sha256_ctrl: RTL and testbench
=====================================

// Module: pbkdf2_sha256_ctrl
// PURPOSE
//  Iteration sequencer for PBKDF2-HMAC-SHA256 with a single 256-bit output block (dkLen = 32 B, block index 1).
//  Accepts password, salt and iteration count, then drives one hmac_sha256 core c times:
//    U1 = HMAC(P, S||INT(1)), Uj = HMAC(P, Uj-1).
//  Accumulates T = U1 ^ U2 ^ ... ^ Uc and presents T on a valid/ready output.
//  Sits between the top-level request interface and the shared HMAC core.
// PARAMETERS
//  ITER_W    32   width of the iteration count and iteration counter
//  SALT_MAX  51   max salt bytes; salt + 4-byte INT must fit the core's 55-byte single-block limit
// PORTS
//  clk_i        in   1    clock, all logic on posedge
//  rst_ni       in   1    asynchronous reset, active low
//  v_i          in   1    request valid
//  r_o          out  1    request ready (1 only in IDLE)
//  key_i        in   512  password, left aligned, zero padded
//  salt_i       in   512  salt, left aligned; bytes beyond salt_len_i must be 0
//  salt_len_i   in   6    salt length in bytes
//  iter_i       in   ITER_W  iteration count c
//  dk_o         out  256  derived key T
//  err_o        out  1    request rejected (qualified by v_o)
//  v_o          out  1    result valid
//  r_i          in   1    result ready
//  hmac_key_o   out  512  to core key_i
//  hmac_msg_o   out  512  to core msg_i
//  hmac_len_o   out  6    to core msg_len_i (bytes)
//  hmac_v_o     out  1    to core v_i
//  hmac_r_i     in   1    from core r_o
//  hmac_prf_i   in   256  from core prf_o
//  hmac_v_i     in   1    from core v_o
//  hmac_r_o     out  1    to core r_i
// BEHAVIOUR
//  Transfer rule: a transfer occurs on any cycle where valid & ready are both 1.
//    Once asserted, a valid holds its data stable until the transfer completes.
//  Reset (async, rst_ni=0): state=IDLE; acc, cnt, dk_o, err_o, msg/key/len regs = 0.
//    v_o=0, hmac_v_o=0, hmac_r_o=0, r_o=1 (IDLE decode).
//  Reset mid-operation: in-flight work is abandoned and no result is produced.
//    The HMAC core must be reset in the same event.
//  FSM: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  IDLE: r_o=1. On v_i transfer:
//    - latch key_reg = key_i and iter_reg = iter_i; set cnt = 0.
//    - msg_reg = salt_i | ({32'h00000001, 480'b0} >> 8*salt_len_i); len_reg = salt_len_i + 4.
//    - if iter_i == 0 or salt_len_i > SALT_MAX: err_o = 1, dk_o = 0, go to DONE.
//    - otherwise: err_o = 0, go to ISSUE.
//  ISSUE: hmac_v_o = 1; hmac_* outputs driven from key_reg, msg_reg and len_reg.
//    On hmac_r_i, go to WAIT.
//  WAIT: hmac_r_o = 1. On hmac_v_i transfer:
//    - acc = (cnt == 0) ? hmac_prf_i : acc ^ hmac_prf_i; cnt++.
//    - msg_reg = {hmac_prf_i, 256'b0}; len_reg = 32.
//    - if cnt + 1 == iter_reg: dk_o = next acc, go to DONE; else go to ISSUE.
//  DONE: v_o = 1; dk_o and err_o held stable. On r_i, go to IDLE.
//    v_i is ignored here (r_o = 0).
//  The controller never asserts hmac_v_o and hmac_r_o in the same cycle.
//  Latency: 1 + c * (core latency + 2) cycles from request transfer to v_o.
//  cnt does not wrap: iter_i = 2^ITER_W - 1 completes normally.
// STRUCTURE
//  Shared package pbkdf2_pkg: state enum typedef {IDLE, ISSUE, WAIT, DONE}.
//    Also constants INT_BLOCK1 = 32'h1, PRF_LEN_B = 6'd32, SALT_MAX.
//  Single module with one FSM. The HMAC core is instantiated by the parent, not here.
// TESTING (bench instantiates hmac_sha256 behind this block)
//  P="password", S="salt" (len 4), c=1 -> dk_o=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b.
//  Same P and S, c=2 -> dk_o=ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
//  Same P and S, c=4096 -> dk_o=c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a.
//    Also check exactly 4096 core transfers.
//  Error paths: iter_i=0 -> err_o=1, dk_o=0, no hmac_v_o pulse.
//    salt_len_i=52 -> same response.
//  Backpressure: hold r_i=0 for 10 cycles in DONE -> v_o and dk_o stable.
//    A second v_i in that window is not accepted.
//  Reset: drop rst_ni during iteration 2 of c=4 -> outputs at reset values next edge.
//    A fresh c=1 request then returns the c=1 vector.

Source files
------------

// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2-HMAC-SHA256 iteration sequencer.
package pbkdf2_pkg;

    // Sequencer states: wait for a request, hand a message to the core,
    // wait for its PRF, hold the final result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Big-endian block index appended to the salt for the first HMAC.
    localparam logic [31:0] INT_BLOCK1 = 32'h0000_0001;

    // Every HMAC after the first hashes the previous 32-byte PRF.
    localparam logic [5:0]  PRF_LEN_B  = 6'd32;

    // Salt plus the 4-byte block index must fit the core's 55-byte message.
    localparam int          SALT_MAX   = 51;

endpackage

// File: rtl/pbkdf2_sha256_ctrl.sv
// PBKDF2-HMAC-SHA256 sequencer for a single 32-byte output block.
// Runs one external HMAC core c times (U1 = HMAC(P, S||INT(1)),
// Uj = HMAC(P, Uj-1)) and returns T = U1 ^ ... ^ Uc.
//
// Handshakes: every interface (request, result, core request, core
// response) transfers on a cycle where valid and ready are both 1; a
// valid, once raised, keeps its payload stable until that transfer.
module pbkdf2_sha256_ctrl
    import pbkdf2_pkg::*;
#(
    parameter int ITER_W   = 32,
    parameter int SALT_MAX = pbkdf2_pkg::SALT_MAX
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // request side
    input  logic              v_i,
    output logic              r_o,
    input  logic [511:0]      key_i,
    input  logic [511:0]      salt_i,
    input  logic [5:0]        salt_len_i,
    input  logic [ITER_W-1:0] iter_i,
    // result side
    output logic [255:0]      dk_o,
    output logic              err_o,
    output logic              v_o,
    input  logic              r_i,
    // HMAC core side
    output logic [511:0]      hmac_key_o,
    output logic [511:0]      hmac_msg_o,
    output logic [5:0]        hmac_len_o,
    output logic              hmac_v_o,
    input  logic              hmac_r_i,
    input  logic [255:0]      hmac_prf_i,
    input  logic              hmac_v_i,
    output logic              hmac_r_o
);

    localparam logic [5:0] SaltMaxB = 6'(SALT_MAX);

    state_e              state_q;
    logic [511:0]        key_q;
    logic [511:0]        msg_q;
    logic [5:0]          len_q;
    logic [ITER_W-1:0]   iter_q;
    logic [ITER_W-1:0]   cnt_q;
    logic [255:0]        acc_q;
    logic [255:0]        dk_q;
    logic                err_q;
    logic                v_q;
    logic                hmac_v_q;
    logic                hmac_r_q;

    logic [511:0]        msg_first_d;
    logic [5:0]          len_first_d;
    logic                req_bad_d;
    logic [255:0]        acc_d;
    logic [ITER_W-1:0]   cnt_d;

    // Next-value helpers: first message (salt || INT(1)), request
    // validity, running XOR and iteration count after a core response.
    always_comb begin
        msg_first_d = salt_i | ({INT_BLOCK1, 480'b0} >> {salt_len_i, 3'b000});
        len_first_d = salt_len_i + 6'd4;
        req_bad_d   = (iter_i == '0) || (salt_len_i > SaltMaxB);
        acc_d       = (cnt_q == '0) ? hmac_prf_i : (acc_q ^ hmac_prf_i);
        cnt_d       = cnt_q + ITER_W'(1);
    end

    // Sequencer FSM with all handshake and data outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            key_q    <= '0;
            msg_q    <= '0;
            len_q    <= '0;
            iter_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            dk_q     <= '0;
            err_q    <= 1'b0;
            v_q      <= 1'b0;
            hmac_v_q <= 1'b0;
            hmac_r_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i) begin
                        key_q  <= key_i;
                        iter_q <= iter_i;
                        cnt_q  <= '0;
                        msg_q  <= msg_first_d;
                        len_q  <= len_first_d;
                        if (req_bad_d) begin
                            // Rejected requests answer immediately, no core use.
                            err_q   <= 1'b1;
                            dk_q    <= '0;
                            v_q     <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            err_q    <= 1'b0;
                            hmac_v_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (hmac_r_i) begin
                        hmac_v_q <= 1'b0;
                        hmac_r_q <= 1'b1;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (hmac_v_i) begin
                        acc_q    <= acc_d;
                        cnt_q    <= cnt_d;
                        msg_q    <= {hmac_prf_i, 256'b0};
                        len_q    <= PRF_LEN_B;
                        hmac_r_q <= 1'b0;
                        if (cnt_d == iter_q) begin
                            dk_q    <= acc_d;
                            v_q     <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            hmac_v_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (r_i) begin
                        v_q     <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r_o        = (state_q == IDLE);
    assign v_o        = v_q;
    assign dk_o       = dk_q;
    assign err_o      = err_q;
    assign hmac_key_o = key_q;
    assign hmac_msg_o = msg_q;
    assign hmac_len_o = len_q;
    assign hmac_v_o   = hmac_v_q;
    assign hmac_r_o   = hmac_r_q;

endmodule

// File: tb/tb_pbkdf2_sha256_ctrl.sv
// Bench for pbkdf2_sha256_ctrl: a behavioural HMAC-SHA256 core sits behind
// the sequencer, a PBKDF2 reference model predicts results into exp_q and
// a monitor checks every result handshake against it.
`timescale 1ns/1ps
module tb_pbkdf2_sha256_ctrl;

    localparam int REQ_BUDGET = 2000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         v_i = 1'b0;
    logic         r_o;
    logic [511:0] key_i = '0;
    logic [511:0] salt_i = '0;
    logic [5:0]   salt_len_i = '0;
    logic [31:0]  iter_i = '0;
    logic [255:0] dk_o;
    logic         err_o;
    logic         v_o;
    logic         r_i = 1'b0;
    logic [511:0] hmac_key_o;
    logic [511:0] hmac_msg_o;
    logic [5:0]   hmac_len_o;
    logic         hmac_v_o;
    logic         hmac_r_i;
    logic [255:0] hmac_prf_i;
    logic         hmac_v_i;
    logic         hmac_r_o;

    pbkdf2_sha256_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .v_i        (v_i),
        .r_o        (r_o),
        .key_i      (key_i),
        .salt_i     (salt_i),
        .salt_len_i (salt_len_i),
        .iter_i     (iter_i),
        .dk_o       (dk_o),
        .err_o      (err_o),
        .v_o        (v_o),
        .r_i        (r_i),
        .hmac_key_o (hmac_key_o),
        .hmac_msg_o (hmac_msg_o),
        .hmac_len_o (hmac_len_o),
        .hmac_v_o   (hmac_v_o),
        .hmac_r_i   (hmac_r_i),
        .hmac_prf_i (hmac_prf_i),
        .hmac_v_i   (hmac_v_i),
        .hmac_r_o   (hmac_r_o)
    );

    // ---------------- SHA-256 / HMAC / PBKDF2 reference ----------------
    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_H0 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_block(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [0:63];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
        e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
    endfunction

    // Final padded block: len message bytes (<= 55), 0x80, bit length of total.
    function automatic logic [511:0] pad_blk(input logic [511:0] msg, input int len, input int total);
        logic [511:0] ones;
        logic [511:0] blk;
        ones = '1;
        blk = msg & ~(ones >> (8 * len));
        blk[511 - 8*len -: 8] = 8'h80;
        blk[63:0] = 64'(total * 8);
        return blk;
    endfunction

    function automatic logic [255:0] hmac_ref(input logic [511:0] key, input logic [511:0] msg, input int len);
        logic [255:0] inner;
        inner = sha_block(sha_block(SHA_H0, key ^ {64{8'h36}}), pad_blk(msg, len, 64 + len));
        return sha_block(sha_block(SHA_H0, key ^ {64{8'h5c}}), pad_blk({inner, 256'b0}, 32, 96));
    endfunction

    // PBKDF2 response {err, dk} straight from the algorithm definition.
    function automatic logic [256:0] pbkdf2_ref(input logic [511:0] key, input logic [511:0] salt,
                                               input int slen, input logic [31:0] iter);
        logic [511:0] m;
        logic [255:0] u;
        logic [255:0] t;
        if (iter == 0 || slen > 51) return {1'b1, 256'b0};
        m = '0;
        for (int b = 0; b < slen; b++) m[511 - 8*b -: 8] = salt[511 - 8*b -: 8];
        m[511 - 8*(slen + 3) -: 8] = 8'h01;
        u = hmac_ref(key, m, slen + 4);
        t = u;
        for (int unsigned j = 2; j <= iter; j++) begin
            u = hmac_ref(key, {u, 256'b0}, 32);
            t = t ^ u;
        end
        return {1'b0, t};
    endfunction

    function automatic logic [511:0] rand_bytes(input int n);
        logic [511:0] v;
        v = '0;
        for (int b = 0; b < n; b++) v[511 - 8*b -: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    // ---------------- behavioural HMAC core ----------------
    int           core_st = 0;    // 0 idle, 1 computing, 2 presenting
    int           core_cnt = 0;
    int           core_acc_n = 0; // accepted core requests
    logic         core_stall = 1'b0;
    logic [255:0] core_res = '0;

    assign hmac_r_i   = (core_st == 0) && !core_stall;
    assign hmac_v_i   = (core_st == 2);
    assign hmac_prf_i = core_res;

    // Core shares the controller's reset; random latency and accept stalls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_st    <= 0;
            core_cnt   <= 0;
            core_res   <= '0;
            core_stall <= 1'b0;
        end else begin
            core_stall <= ($urandom_range(0, 3) == 0);
            case (core_st)
                0: if (hmac_v_o && hmac_r_i) begin
                    core_res   <= hmac_ref(hmac_key_o, hmac_msg_o, int'(hmac_len_o));
                    core_cnt   <= $urandom_range(0, 2);
                    core_acc_n <= core_acc_n + 1;
                    core_st    <= 1;
                end
                1: if (core_cnt == 0) core_st <= 2; else core_cnt <= core_cnt - 1;
                2: if (hmac_r_o) core_st <= 0;
                default: core_st <= 0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    logic [256:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int overlap_n = 0;
    int hv_seen = 0;
    bit rand_ri = 1'b1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every result transfer.
    initial begin
        logic [256:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hmac_v_o && hmac_r_o) overlap_n++;
                if (hmac_v_o) hv_seen++;
                if (v_o && r_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got err=%0b dk=%0h expected no result", err_o, dk_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {255'b0, err_o, dk_o}, {255'b0, e});
                    end
                end
            end
        end
    end

    // Random result backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ri) r_i = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [511:0] key, input logic [511:0] salt,
                            input logic [5:0] slen, input logic [31:0] iter);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        key_i = key; salt_i = salt; salt_len_i = slen; iter_i = iter; v_i = 1'b1;
        forever begin
            @(negedge clk);
            if (r_o) break;
            n++;
            if (n > REQ_BUDGET) begin
                n_checks++;
                n_fail++;
                $display("FAIL req_accept: r_o got 0 expected 1 within %0d cycles", REQ_BUDGET);
                break;
            end
        end
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic req(input logic [511:0] key, input logic [511:0] salt,
                       input logic [5:0] slen, input logic [31:0] iter, input logic [256:0] exp);
        exp_q.push_back(exp);
        send_req(key, salt, slen, iter);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_v_o"},       {511'b0, v_o},      512'd0);
        check({p, "_r_o"},       {511'b0, r_o},      512'd1);
        check({p, "_hmac_v_o"},  {511'b0, hmac_v_o}, 512'd0);
        check({p, "_hmac_r_o"},  {511'b0, hmac_r_o}, 512'd0);
        check({p, "_dk_o"},      {256'b0, dk_o},     512'd0);
        check({p, "_err_o"},     {511'b0, err_o},    512'd0);
        check({p, "_hmac_key"},  hmac_key_o,         512'd0);
        check({p, "_hmac_msg"},  hmac_msg_o,         512'd0);
        check({p, "_hmac_len"},  {506'b0, hmac_len_o}, 512'd0);
    endtask

    // ---------------- test sequence ----------------
    localparam logic [255:0] DK_C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] DK_C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [255:0] DK_C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;

    initial begin
        logic [511:0] pw;
        logic [511:0] st;
        logic [511:0] key;
        logic [511:0] salt;
        int           slen;
        int           base;
        int           hv_base;
        int           n;

        pw = {64'h70617373776f7264, 448'b0};   // "password"
        st = {32'h73616c74, 480'b0};           // "salt"

        // reset state
        #23;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // known-answer vectors
        req(pw, st, 6'd4, 32'd1, {1'b0, DK_C1});
        req(pw, st, 6'd4, 32'd2, {1'b0, DK_C2});
        wait_idle("kat", 2000);

        base = core_acc_n;
        req(pw, st, 6'd4, 32'd4096, {1'b0, DK_C4096});
        wait_idle("kat4096", 60000);
        check("core_xfers_4096", 512'(core_acc_n - base), 512'd4096);

        // error paths: no core activity at all
        base = core_acc_n;
        hv_base = hv_seen;
        req(pw, st, 6'd4, 32'd0, {1'b1, 256'b0});
        wait_idle("err_iter0", 200);
        check("err_iter0_no_core", 512'(core_acc_n - base), 512'd0);
        check("err_iter0_no_hv", 512'(hv_seen - hv_base), 512'd0);

        salt = rand_bytes(52);
        req(pw, salt, 6'd52, 32'd1, {1'b1, 256'b0});
        wait_idle("err_salt52", 200);
        check("err_salt52_no_core", 512'(core_acc_n - base), 512'd0);
        check("err_salt52_no_hv", 512'(hv_seen - hv_base), 512'd0);

        // randomized requests against the reference model
        for (int t = 0; t < 10; t++) begin
            key = rand_bytes($urandom_range(1, 64));
            case (t)
                0: slen = 0;
                1: slen = 51;
                9: slen = 63;
                default: slen = $urandom_range(0, 51);
            endcase
            salt = rand_bytes(slen);
            iter_i = iter_i;
            begin
                logic [31:0] it;
                it = (t == 8) ? 32'd0 : 32'($urandom_range(1, 5));
                req(key, salt, 6'(slen), it, pbkdf2_ref(key, salt, slen, it));
            end
        end
        wait_idle("random", 5000);

        // backpressure in DONE; a second request must not be taken
        rand_ri = 1'b0;
        r_i = 1'b0;
        req(pw, st, 6'd4, 32'd1, {1'b0, DK_C1});
        n = 0;
        while (!v_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_v_o_rise", {511'b0, v_o}, 512'd1);
        base = core_acc_n;
        @(posedge clk);
        #1;
        key_i = pw; salt_i = st; salt_len_i = 6'd4; iter_i = 32'd2; v_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_v_o_hold", {511'b0, v_o}, 512'd1);
            check("bp_dk_hold", {256'b0, dk_o}, {256'b0, DK_C1});
            check("bp_r_o_low", {511'b0, r_o}, 512'd0);
        end
        @(posedge clk);
        #1;
        v_i = 1'b0;
        r_i = 1'b1;
        rand_ri = 1'b1;
        wait_idle("bp", 200);
        repeat (20) @(posedge clk);
        check("bp_second_not_taken", 512'(core_acc_n - base), 512'd0);

        // reset in the middle of iteration 2 of a c=4 request
        base = core_acc_n;
        send_req(pw, st, 6'd4, 32'd4);
        n = 0;
        while (core_acc_n < base + 2 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("rst_reached_iter2", 512'(core_acc_n - base), 512'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        #1;
        check_reset_vals("midrst_edge");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req(pw, st, 6'd4, 32'd1, {1'b0, DK_C1});
        wait_idle("after_rst", 2000);

        check("no_v_and_r_overlap", 512'(overlap_n), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
